// File: rtl/clk_div_bank_pkg.sv
// Shared definitions for the car timing-domain clock divider bank.
package clk_div_bank_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_STROBE = 1'b1
    } mode_e;

    localparam int unsigned CLK_HZ = 50_000_000;

    // Divisor giving a square wave of f_hz on clk_out (half-period count).
    function automatic logic [31:0] hz_to_div(input int unsigned f_hz);
        return (f_hz == 0) ? 32'd0 : 32'(CLK_HZ / (2 * f_hz));
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor programming port of the clock divider bank.
interface clk_div_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic             div_we;
    logic [CH_W-1:0]  div_sel;
    logic [CNT_W-1:0] div_data;
    logic             div_ack;
    logic [N_CH-1:0]  div_busy;

    modport master (output div_we, div_sel, div_data, input  div_ack, div_busy);
    modport slave  (input  div_we, div_sel, div_data, output div_ack, div_busy);
endinterface

// File: rtl/clk_div_bank_ch.sv
// One divider channel: counter, active/pending divisor, square or strobe output.
module clk_div_bank_ch
    import clk_div_bank_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 25_000_000
) (
    input  logic             clk_M,
    input  logic             reset,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wdata_i,
    output logic             busy_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
    logic             busy_q, busy_d, clk_q, clk_d, tick_q, tick_d;
    logic             en_q;
    mode_e            mode_q, mode_m;
    logic             tc, restart, apply;

    always_comb begin
        mode_m  = mode_e'(mode_i);
        tc      = (cnt_q == (div_q - CNT_W'(1)));
        // A mode change only restarts a channel that was already running.
        restart = !en_i || sync_i || (en_q && (mode_m != mode_q));
        // Pending divisor lands only on a period boundary, so no runt pulses.
        apply   = busy_q && (!en_i || sync_i || (!restart && tc));

        cnt_d  = cnt_q + CNT_W'(1);
        clk_d  = (mode_m == MODE_SQUARE) ? clk_q : 1'b0;
        tick_d = 1'b0;
        div_d  = div_q;
        pend_d = pend_q;
        busy_d = busy_q;

        if (restart) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = (mode_m == MODE_SQUARE) ? ~clk_q : 1'b1;
        end

        if (apply) begin
            div_d  = pend_q;
            busy_d = 1'b0;
        end

        // A write on the same edge as an apply becomes the next pending value.
        if (wr_i) begin
            pend_d = (wdata_i == '0) ? CNT_W'(1) : wdata_i;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_M or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEF_DIV);
            pend_q <= '0;
            busy_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            en_q   <= 1'b0;
            mode_q <= MODE_SQUARE;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            en_q   <= en_i;
            mode_q <= mode_m;
        end
    end

    assign busy_o    = busy_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock/tick generator for the car timing domains.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int          N_CH    = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 25_000_000
) (
    input  logic            clk_M,
    input  logic            reset,
    input  logic [N_CH-1:0] en_i,
    input  logic [N_CH-1:0] mode_i,
    input  logic            sync_i,
    clk_div_bank_if.slave   bus,
    output logic [N_CH-1:0] clk_out_o,
    output logic [N_CH-1:0] tick_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            ack_q;
    logic [N_CH-1:0] wr, busy;

    // Every write is acknowledged, including ones addressed past the last channel.
    always_ff @(posedge clk_M or posedge reset) begin
        if (reset) ack_q <= 1'b0;
        else       ack_q <= bus.div_we;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign wr[g] = bus.div_we && (bus.div_sel == CH_W'(g));

        clk_div_bank_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_M     (clk_M),
            .reset     (reset),
            .en_i      (en_i[g]),
            .mode_i    (mode_i[g]),
            .sync_i    (sync_i),
            .wr_i      (wr[g]),
            .wdata_i   (bus.div_data),
            .busy_o    (busy[g]),
            .clk_out_o (clk_out_o[g]),
            .tick_o    (tick_o[g])
        );
    end

    assign bus.div_ack  = ack_q;
    assign bus.div_busy = busy;

endmodule
